// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NOP_INSTR   : bubble instruction (addi x0,x0,0)
//   pc_sel_e    : which source feeds the next PC
//   next_pc_sel : next-PC source, ordered from highest to lowest priority
// The BTB entry struct lives in fetch_btb, because its field widths follow
// that module's parameters.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_PRED,
    SEL_SEQ
  } pc_sel_e;

  // A resolved redirect from ME beats a stall: the redirecting branch is
  // older than whatever instruction the hazard unit is holding.
  function automatic pc_sel_e next_pc_sel(input logic rst, input logic redirect,
                                          input logic hold, input logic hit);
    if (rst)           return SEL_RESET;
    else if (redirect) return SEL_REDIRECT;
    else if (hold)     return SEL_HOLD;
    else if (hit)      return SEL_PRED;
    else               return SEL_SEQ;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer. It is built only when FETCH_BTB_EN is
// defined.
//   clk, reset               : clock and synchronous active-high reset
//                              (reset clears all valid bits)
//   lookup_pc                : current fetch PC
//   hit, target              : combinational lookup result
//   upd_en, upd_pc,
//   upd_target, upd_taken    : write port. taken=1 installs the entry,
//                              taken=0 invalidates it.
// Writes land at the clock edge. A lookup in the same cycle therefore sees
// the old entry.
module fetch_btb #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            hit,
  output logic [PC_W-1:0] target,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int ENTRIES = 2**IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  btb_entry_t       rd_entry;

  assign rd_idx   = lookup_pc[IDX_W-1:0];
  assign wr_idx   = upd_pc[IDX_W-1:0];
  assign rd_entry = '{valid: valid_q[rd_idx], tag: tag_q[rd_idx], target: target_q[rd_idx]};
  assign hit      = rd_entry.valid && (rd_entry.tag == lookup_pc[PC_W-1:IDX_W]);
  assign target   = rd_entry.target;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_en) begin
      valid_q[wr_idx] <= upd_taken;
    end
  end

  // The tag and target fields are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      tag_q[wr_idx]    <= upd_pc[PC_W-1:IDX_W];
      target_q[wr_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/rom.sv
// Combinational instruction ROM. Its contents come from the INIT parameter.
// Word i occupies INIT[i*DATA_W +: DATA_W].
//   addr : word address
//   data : word at addr, available in the same cycle
module rom #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter logic [DATA_W*(2**ADDR_W)-1:0] INIT = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  assign data = INIT[addr*DATA_W +: DATA_W];

endmodule

// File: rtl/fetch_stage_v2.sv
// IF stage of the 5-stage RISC-V pipeline. It holds the word-addressed PC,
// reads the instruction ROM and loads the IF/DE register.
// Optional feature: define FETCH_BTB_EN to add a direct-mapped BTB that
// predicts the next PC.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   stall_i                    : hold the PC and the IF/DE register
//   flush_i                    : turn the IF/DE slot into a bubble
//   pc_src_i, pc_branch_i      : redirect from ME
//   upd_en_i, upd_pc_i,
//   upd_target_i, upd_taken_i  : BTB update from ME (ignored without the BTB)
//   instr_o, pc_o, pc_plus1_o,
//   valid_o, pred_taken_o      : IF/DE register
module fetch_stage_v2
  import fetch_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int INSTR_W     = 32,
  parameter int IMEM_ADDR_W = 5,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int BTB_IDX_W   = 3,
  parameter logic [INSTR_W*(2**IMEM_ADDR_W)-1:0] ROM_INIT = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               pc_src_i,
  input  logic [PC_W-1:0]    pc_branch_i,
  input  logic               upd_en_i,
  input  logic [PC_W-1:0]    upd_pc_i,
  input  logic [PC_W-1:0]    upd_target_i,
  input  logic               upd_taken_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus1_o,
  output logic               valid_o,
  output logic               pred_taken_o
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_next;
  logic [PC_W-1:0]    pc_inc;
  logic [INSTR_W-1:0] rom_data;
  logic               btb_hit;
  logic [PC_W-1:0]    btb_target;
  pc_sel_e            pc_sel;

  // Wraps modulo 2^PC_W.
  assign pc_inc = pc_q + PC_W'(1);

  // PCs at or above 2^IMEM_ADDR_W alias onto the low ROM words.
  rom #(
    .ADDR_W (IMEM_ADDR_W),
    .DATA_W (INSTR_W),
    .INIT   (ROM_INIT)
  ) u_rom (
    .addr (pc_q[IMEM_ADDR_W-1:0]),
    .data (rom_data)
  );

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .PC_W  (PC_W),
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (pc_q),
    .hit        (btb_hit),
    .target     (btb_target),
    .upd_en     (upd_en_i),
    .upd_pc     (upd_pc_i),
    .upd_target (upd_target_i),
    .upd_taken  (upd_taken_i)
  );
`else
  localparam int unused_btb_idx_w = BTB_IDX_W;
  logic unused_upd;
  assign unused_upd = ^{upd_en_i, upd_pc_i, upd_target_i, upd_taken_i};
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
`endif

  always_comb begin
    pc_sel  = next_pc_sel(reset, pc_src_i, stall_i, btb_hit);
    pc_next = pc_inc;
    case (pc_sel)
      SEL_RESET:    pc_next = RESET_PC;
      SEL_REDIRECT: pc_next = pc_branch_i;
      SEL_HOLD:     pc_next = pc_q;
      SEL_PRED:     pc_next = btb_target;
      SEL_SEQ:      pc_next = pc_inc;
      default:      pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_next;
  end

  // A flush overrides a stall. A bubble keeps the pc fields, so that
  // downstream debug still sees where the slot came from.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_o      <= NOP;
      pc_o         <= '0;
      pc_plus1_o   <= '0;
      valid_o      <= 1'b0;
      pred_taken_o <= 1'b0;
    end else if (flush_i) begin
      instr_o      <= NOP;
      valid_o      <= 1'b0;
      pred_taken_o <= 1'b0;
    end else if (!stall_i) begin
      instr_o      <= rom_data;
      pc_o         <= pc_q;
      pc_plus1_o   <= pc_inc;
      valid_o      <= 1'b1;
      pred_taken_o <= btb_hit;
    end
  end

endmodule

// File: tb/tb_fetch_stage_v2.sv
// Directed scoreboard bench for fetch_stage_v2. Each step pushes the expected
// IF/DE contents, advances one clock and compares. A second instance with
// PC_W=8 exercises PC wrap-around.
module tb_fetch_stage_v2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] romw(input int unsigned i);
    return 32'hCAFE_0000 + (i % 32) * 32'h0001_0011;
  endfunction

  function automatic logic [31:0] rom8w(input int unsigned i);
    return 32'h0B0B_0000 | (i % 32);
  endfunction

  function automatic logic [1023:0] build_rom(input bit alt);
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = alt ? rom8w(i) : romw(i);
    return r;
  endfunction

  localparam logic [1023:0] ROM_MAIN = build_rom(1'b0);
  localparam logic [1023:0] ROM_8    = build_rom(1'b1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, pc_src = 1'b0;
  logic [31:0] pc_branch = '0, upd_pc = '0, upd_target = '0;
  logic        upd_en = 1'b0, upd_taken = 1'b0;
  logic [31:0] instr, pc, pc1;
  logic        valid, pred;

  logic        reset8 = 1'b1, zero_bit = 1'b0;
  logic [7:0]  zero8 = '0;
  logic [31:0] instr8;
  logic [7:0]  pc8, pc1_8;
  logic        valid8, pred8;

  fetch_stage_v2 #(
    .PC_W(32), .INSTR_W(32), .IMEM_ADDR_W(5), .RESET_PC(32'd4),
    .BTB_IDX_W(3), .ROM_INIT(ROM_MAIN)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
    .pc_src_i(pc_src), .pc_branch_i(pc_branch),
    .upd_en_i(upd_en), .upd_pc_i(upd_pc), .upd_target_i(upd_target),
    .upd_taken_i(upd_taken),
    .instr_o(instr), .pc_o(pc), .pc_plus1_o(pc1), .valid_o(valid),
    .pred_taken_o(pred)
  );

  fetch_stage_v2 #(
    .PC_W(8), .INSTR_W(32), .IMEM_ADDR_W(5), .RESET_PC(8'hFE),
    .BTB_IDX_W(3), .ROM_INIT(ROM_8)
  ) dut8 (
    .clk(clk), .reset(reset8), .stall_i(zero_bit), .flush_i(zero_bit),
    .pc_src_i(zero_bit), .pc_branch_i(zero8),
    .upd_en_i(zero_bit), .upd_pc_i(zero8), .upd_target_i(zero8),
    .upd_taken_i(zero_bit),
    .instr_o(instr8), .pc_o(pc8), .pc_plus1_o(pc1_8), .valid_o(valid8),
    .pred_taken_o(pred8)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc1;
    logic        valid;
    logic        pred;
  } obs_t;

  typedef struct {
    string tag;
    bit    which;
    obs_t  v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic obs_t observe(input bit which);
    obs_t o;
    if (which) o = '{instr: instr8, pc: {24'b0, pc8}, pc1: {24'b0, pc1_8}, valid: valid8, pred: pred8};
    else       o = '{instr: instr, pc: pc, pc1: pc1, valid: valid, pred: pred};
    return o;
  endfunction

  task automatic push(input string tag, input bit which, input logic [31:0] i,
                      input logic [31:0] p, input logic [31:0] p1,
                      input logic v, input logic pr);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.v     = '{instr: i, pc: p, pc1: p1, valid: v, pred: pr};
    sb_q.push_back(e);
  endtask

  task automatic compare_one();
    exp_t e;
    obs_t o;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb_q.pop_front();
      o = observe(e.which);
      assert (o === e.v) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_one();
  endtask

  // Expect a real fetch from pc p on the main instance.
  task automatic step(input string tag, input int unsigned p, input logic pr);
    push(tag, 1'b0, romw(p), p, p + 1, 1'b1, pr);
    tick();
  endtask

  task automatic step_raw(input string tag, input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] p1, input logic v, input logic pr);
    push(tag, 1'b0, i, p, p1, v, pr);
    tick();
  endtask

  task automatic step8(input string tag, input int unsigned p);
    push(tag, 1'b1, rom8w(p), p % 256, (p + 1) % 256, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push("reset_state", 1'b0, NOP, 0, 0, 1'b0, 1'b0);
    compare_one();

    step("seq_a", 4, 0);
    step("seq_b", 5, 0);
    step("seq_c", 6, 0);

    reset = 1'b1;
    step_raw("rereset", NOP, 0, 0, 0, 0);
    reset = 1'b0;

    step("s2_a", 4, 0);
    step("s2_b", 5, 0);
    stall = 1'b1;
    step("stall_hold1", 5, 0);
    step("stall_hold2", 5, 0);
    stall = 1'b0;
    step("stall_resume", 6, 0);
    step("stall_next", 7, 0);

    pc_src = 1'b1; pc_branch = 32'd20; flush = 1'b1; stall = 1'b1;
    step_raw("flush_bubble", NOP, 7, 8, 0, 0);
    pc_src = 1'b0; flush = 1'b0; stall = 1'b0;
    step("redirect_target", 20, 0);
    step("redirect_seq", 21, 0);

    flush = 1'b1;
    step_raw("flush_only", NOP, 21, 22, 0, 0);
    flush = 1'b0;
    step("flush_pc_advanced", 23, 0);

    pc_src = 1'b1; pc_branch = 32'd3;
    step("redirect_noflush", 24, 0);
    pc_src = 1'b0;
    step("redirect_to_3", 3, 0);

    pc_src = 1'b1; pc_branch = 32'd40;
    step("pre_alias", 4, 0);
    pc_src = 1'b0;
    step_raw("rom_alias", romw(8), 40, 41, 1, 0);

    stall = 1'b1; pc_src = 1'b1; pc_branch = 32'd10;
    step_raw("redirect_over_stall", romw(8), 40, 41, 1, 0);
    stall = 1'b0; pc_src = 1'b0;
    step("redirect_over_stall_tgt", 10, 0);

    upd_en = 1'b1; upd_pc = 32'd13; upd_target = 32'd2; upd_taken = 1'b1;
    step("btb_install", 11, 0);
    upd_en = 1'b0;
    step("btb_pre", 12, 0);
`ifdef FETCH_BTB_EN
    step("btb_hit", 13, 1);
    step("btb_target", 2, 0);
    upd_en = 1'b1; upd_taken = 1'b0; pc_src = 1'b1; pc_branch = 32'd13;
    step("btb_inval", 3, 0);
`else
    step("nobtb_no_pred", 13, 0);
    step("nobtb_seq", 14, 0);
    upd_en = 1'b1; upd_taken = 1'b0; pc_src = 1'b1; pc_branch = 32'd13;
    step("nobtb_inval", 15, 0);
`endif
    upd_en = 1'b0; pc_src = 1'b0;
    step("inval_falls_through", 13, 0);
    step("inval_next", 14, 0);

    upd_en = 1'b1; upd_pc = 32'd5; upd_target = 32'd9; upd_taken = 1'b1;
    step("btb_install5", 15, 0);
    upd_en = 1'b0;
    reset = 1'b1; stall = 1'b1; pc_src = 1'b1; pc_branch = 32'd20;
    step_raw("reset_dominates", NOP, 0, 0, 0, 0);
    reset = 1'b0; stall = 1'b0; pc_src = 1'b0;
    step("post_reset_pc", 4, 0);
    step("btb_cleared", 5, 0);
    step("btb_cleared_next", 6, 0);

    upd_en = 1'b1; upd_pc = 32'd7; upd_target = 32'd1; upd_taken = 1'b1;
    step("same_cycle_old_entry", 7, 0);
    upd_en = 1'b0; pc_src = 1'b1; pc_branch = 32'd7;
    step("same_cycle_next", 8, 0);
    pc_src = 1'b0;
`ifdef FETCH_BTB_EN
    step("btb_hit7", 7, 1);
    step("btb_target1", 1, 0);
    pc_src = 1'b1; pc_branch = 32'd15;
    step("pre_tag", 2, 0);
`else
    step("nobtb_7", 7, 0);
    step("nobtb_8", 8, 0);
    pc_src = 1'b1; pc_branch = 32'd15;
    step("pre_tag", 9, 0);
`endif
    pc_src = 1'b0;
    step("tag_mismatch", 15, 0);
    step("tag_mismatch_next", 16, 0);

    reset8 = 1'b0;
    push("w8_reset", 1'b1, NOP, 0, 0, 1'b0, 1'b0);
    compare_one();
    step8("w8_fe", 32'hFE);
    step8("w8_ff_wrap", 32'hFF);
    step8("w8_zero", 0);
    step8("w8_one", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
